// File: rtl/sp_pkg.sv
// Shared core types and sizes for the register-file writeback slice.
package sp_pkg;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned NUM_REG        = 32;

    localparam int unsigned LD_FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned LD_STARVE_MAX_DEFAULT = 3;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } wb_req_t;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bus bundle for reg_wb_ctrl; signal suffixes are from the controller's point of view.
interface reg_wb_ctrl_if;
    import sp_pkg::*;

    logic                      alu_valid_i;
    logic                      alu_ready_o;
    logic [REG_ADDR_WIDTH-1:0] alu_rd_i;
    logic [XLEN-1:0]           alu_data_i;
    logic                      ld_valid_i;
    logic                      ld_ready_o;
    logic [REG_ADDR_WIDTH-1:0] ld_rd_i;
    logic [XLEN-1:0]           ld_data_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
    logic [XLEN-1:0]           rd_data_o;
    logic                      rd_en_o;
    logic                      sb_set_i;
    logic [REG_ADDR_WIDTH-1:0] sb_set_addr_i;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_i;
    logic                      rs1_busy_o;
    logic                      rs2_busy_o;
    logic [NUM_REG-1:0]        pending_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_valid_i, ld_rd_i, ld_data_i,
        input  sb_set_i, sb_set_addr_i, rs1_addr_i, rs2_addr_i,
        output alu_ready_o, ld_ready_o,
        output rd_addr_o, rd_data_o, rd_en_o,
        output rs1_busy_o, rs2_busy_o, pending_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_valid_i, ld_rd_i, ld_data_i,
        output sb_set_i, sb_set_addr_i, rs1_addr_i, rs2_addr_i,
        input  alu_ready_o, ld_ready_o,
        input  rd_addr_o, rd_data_o, rd_en_o,
        input  rs1_busy_o, rs2_busy_o, pending_o
    );
endinterface

// File: rtl/sp_fifo.sv
// Synchronous FIFO of writeback requests; pointers carry a wrap bit for full/empty.
module sp_fifo
    import sp_pkg::*;
#(
    parameter int unsigned DEPTH = LD_FIFO_DEPTH_DEFAULT
) (
    input  logic    clk_i,
    input  logic    arst_i,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    output logic    full_o,
    input  logic    pop_i,
    output wb_req_t pop_data_o,
    output logic    empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_req_t     mem_q [DEPTH];
    logic        push_en;
    logic        pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
endmodule

// File: rtl/reg_wb_ctrl.sv
// Merges ALU and buffered load results onto the single register-file write port
// and tracks in-flight destinations for issue-stage hazard checks.
module reg_wb_ctrl
    import sp_pkg::*;
#(
    parameter int unsigned LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEFAULT,
    parameter int unsigned LD_STARVE_MAX = LD_STARVE_MAX_DEFAULT
) (
    input  logic         clk_i,
    input  logic         arst_i,
    reg_wb_ctrl_if.slave bus
);
    localparam int unsigned SW = $clog2(LD_STARVE_MAX + 1);

    logic                      fifo_full;
    logic                      fifo_empty;
    wb_req_t                   ld_req;
    wb_req_t                   ld_head;
    wb_req_t                   win_req;
    logic                      force_ld;
    logic                      alu_win;
    logic                      ld_push;
    logic                      ld_pop;
    logic                      win_valid;

    logic [SW-1:0]             starve_q, starve_d;
    logic                      rd_en_q, rd_en_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]           rd_data_q, rd_data_d;
    logic [NUM_REG-1:0]        pending_q, pending_d;

    assign force_ld        = (starve_q == SW'(LD_STARVE_MAX));
    assign bus.alu_ready_o = !arst_i && !force_ld;
    assign bus.ld_ready_o  = !arst_i && !fifo_full;

    assign alu_win   = bus.alu_valid_i && bus.alu_ready_o;
    assign ld_pop    = !alu_win && !fifo_empty;
    assign ld_push   = bus.ld_valid_i && bus.ld_ready_o;
    assign win_valid = alu_win || ld_pop;

    assign ld_req = '{rd: bus.ld_rd_i, data: bus.ld_data_i};

    sp_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .push_i      (ld_push),
        .push_data_i (ld_req),
        .full_o      (fifo_full),
        .pop_i       (ld_pop),
        .pop_data_o  (ld_head),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        win_req = ld_head;
        if (alu_win) win_req = '{rd: bus.alu_rd_i, data: bus.alu_data_i};

        starve_d = '0;
        if (!fifo_empty && !ld_pop)
            starve_d = force_ld ? starve_q : starve_q + 1'b1;

        // x0 results complete their handshake but never reach the port.
        rd_en_d   = win_valid && (win_req.rd != '0);
        rd_addr_d = rd_en_d ? win_req.rd   : rd_addr_q;
        rd_data_d = rd_en_d ? win_req.data : rd_data_q;

        // Clear from the write issued last cycle first, so a same-address set wins.
        pending_d = pending_q;
        if (rd_en_q) pending_d[rd_addr_q] = 1'b0;
        if (bus.sb_set_i && (bus.sb_set_addr_i != '0)) pending_d[bus.sb_set_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            starve_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            pending_q <= '0;
        end else begin
            starve_q  <= starve_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pending_q <= pending_d;
        end
    end

    assign bus.rd_en_o    = rd_en_q;
    assign bus.rd_addr_o  = rd_addr_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.pending_o  = pending_q;
    assign bus.rs1_busy_o = pending_q[bus.rs1_addr_i];
    assign bus.rs2_busy_o = pending_q[bus.rs2_addr_i];

    // A destination may only be re-marked in the cycle its previous write retires.
    a_no_double_issue: assert property (
        @(posedge clk_i) disable iff (arst_i)
        (bus.sb_set_i && (bus.sb_set_addr_i != '0)) |->
            (!pending_q[bus.sb_set_addr_i] || (rd_en_q && (rd_addr_q == bus.sb_set_addr_i)))
    );
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: ALU/load writeback, FIFO full, starvation, x0, scoreboard, reset.
module tb_reg_wb_ctrl;
    import sp_pkg::*;

    logic clk = 1'b0;
    logic arst;
    int   n_assert = 0;
    int   n_fail   = 0;

    reg_wb_ctrl_if bus ();

    reg_wb_ctrl #(
        .LD_FIFO_DEPTH (4),
        .LD_STARVE_MAX (3)
    ) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.alu_valid_i   = 1'b0;
        bus.alu_rd_i      = '0;
        bus.alu_data_i    = '0;
        bus.ld_valid_i    = 1'b0;
        bus.ld_rd_i       = '0;
        bus.ld_data_i     = '0;
        bus.sb_set_i      = 1'b0;
        bus.sb_set_addr_i = '0;
        bus.rs1_addr_i    = '0;
        bus.rs2_addr_i    = '0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid_i = v;
        bus.alu_rd_i    = rd;
        bus.alu_data_i  = d;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ld_valid_i = v;
        bus.ld_rd_i    = rd;
        bus.ld_data_i  = d;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_en"}, 32'(bus.rd_en_o), 32'(en));
        chk({tag, "_addr"}, 32'(bus.rd_addr_o), 32'(a));
        chk({tag, "_data"}, bus.rd_data_o, d);
    endtask

    initial begin
        arst = 1'b1;
        zero_inputs();
        #2;
        chk_wr("reset", 1'b0, 5'd0, 32'h0);
        chk("reset_pending", bus.pending_o, 32'h0);
        chk("reset_alu_ready", 32'(bus.alu_ready_o), 32'd0);
        chk("reset_ld_ready", 32'(bus.ld_ready_o), 32'd0);

        tick();
        arst = 1'b0;
        #1;
        chk("rel_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        chk("rel_ld_ready", 32'(bus.ld_ready_o), 32'd1);

        // ALU single write with scoreboard tracking of x5
        bus.sb_set_i = 1'b1; bus.sb_set_addr_i = 5'd5; bus.rs1_addr_i = 5'd5; bus.rs2_addr_i = 5'd6;
        #1;
        chk("a_busy_before", 32'(bus.rs1_busy_o), 32'd0);
        tick();
        bus.sb_set_i = 1'b0;
        drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("a_rs1_busy", 32'(bus.rs1_busy_o), 32'd1);
        chk("a_rs2_idle", 32'(bus.rs2_busy_o), 32'd0);
        chk("a_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        chk_wr("a_wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("a_busy_wr_cycle", 32'(bus.rs1_busy_o), 32'd1);
        tick();
        #1;
        chk_wr("a_idle", 1'b0, 5'd5, 32'hDEAD_BEEF);
        chk("a_busy_cleared", 32'(bus.rs1_busy_o), 32'd0);
        chk("a_pending", bus.pending_o, 32'h0);

        // Load single with ALU idle: push, pop, then registered port
        drive_ld(1'b1, 5'd3, 32'h0000_1234);
        #1;
        chk("b_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        #1;
        chk("b_no_wr_yet", 32'(bus.rd_en_o), 32'd0);
        chk("b_ld_ready2", 32'(bus.ld_ready_o), 32'd1);
        tick();
        #1;
        chk_wr("b_wr", 1'b1, 5'd3, 32'h0000_1234);
        tick();
        #1;
        chk("b_idle", 32'(bus.rd_en_o), 32'd0);

        // FIFO fill under ALU priority, then forced drain
        drive_alu(1'b1, 5'd1, 32'h0000_00A1);
        drive_ld(1'b1, 5'd10, 32'h0000_0100);
        #1;
        chk("c0_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        chk("c0_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        tick();
        drive_ld(1'b1, 5'd11, 32'h0000_0101);
        #1;
        chk_wr("c1_wr", 1'b1, 5'd1, 32'h0000_00A1);
        chk("c1_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        tick();
        drive_ld(1'b1, 5'd12, 32'h0000_0102);
        #1;
        chk("c2_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        chk("c2_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        tick();
        drive_ld(1'b1, 5'd13, 32'h0000_0103);
        #1;
        chk("c3_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        chk("c3_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        tick();
        drive_ld(1'b1, 5'd14, 32'h0000_0104);
        #1;
        chk("c4_alu_forced_off", 32'(bus.alu_ready_o), 32'd0);
        chk("c4_ld_full", 32'(bus.ld_ready_o), 32'd0);
        chk_wr("c4_wr", 1'b1, 5'd1, 32'h0000_00A1);
        tick();
        #1;
        chk_wr("c5_forced_ld_wr", 1'b1, 5'd10, 32'h0000_0100);
        chk("c5_alu_back", 32'(bus.alu_ready_o), 32'd1);
        chk("c5_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        #1;
        chk_wr("c6_wr", 1'b1, 5'd1, 32'h0000_00A1);
        chk("c6_full_again", 32'(bus.ld_ready_o), 32'd0);
        tick(); #1;
        chk_wr("c7_wr", 1'b1, 5'd11, 32'h0000_0101);
        tick(); #1;
        chk_wr("c8_wr", 1'b1, 5'd12, 32'h0000_0102);
        tick(); #1;
        chk_wr("c9_wr", 1'b1, 5'd13, 32'h0000_0103);
        tick(); #1;
        chk_wr("c10_wr", 1'b1, 5'd14, 32'h0000_0104);
        tick(); #1;
        chk("c11_idle", 32'(bus.rd_en_o), 32'd0);

        // x0 discard and same-cycle set/clear on x7
        bus.sb_set_i = 1'b1; bus.sb_set_addr_i = 5'd7;
        tick();
        bus.sb_set_i = 1'b0;
        drive_alu(1'b1, 5'd7, 32'h0000_0077);
        #1;
        chk("d_pending7", bus.pending_o, 32'h0000_0080);
        tick();
        bus.sb_set_i = 1'b1; bus.sb_set_addr_i = 5'd7;
        drive_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        chk_wr("d_wr7", 1'b1, 5'd7, 32'h0000_0077);
        chk("d_x0_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        tick();
        bus.sb_set_i = 1'b0;
        drive_alu(1'b1, 5'd7, 32'h0000_0078);
        #1;
        chk_wr("d_x0_no_wr", 1'b0, 5'd7, 32'h0000_0077);
        chk("d_set_wins", bus.pending_o, 32'h0000_0080);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        chk_wr("d_wr7b", 1'b1, 5'd7, 32'h0000_0078);
        tick();
        bus.sb_set_i = 1'b1; bus.sb_set_addr_i = 5'd0;
        #1;
        chk("d_pending_clear", bus.pending_o, 32'h0);
        tick();
        bus.sb_set_i = 1'b0;
        #1;
        chk("d_x0_never_pending", bus.pending_o, 32'h0);

        // Reset in the middle of traffic
        bus.sb_set_i = 1'b1; bus.sb_set_addr_i = 5'd2;
        drive_alu(1'b1, 5'd1, 32'h0000_0005);
        drive_ld(1'b1, 5'd20, 32'h0000_0200);
        tick();
        bus.sb_set_addr_i = 5'd3;
        drive_ld(1'b1, 5'd21, 32'h0000_0201);
        tick();
        bus.sb_set_i = 1'b0;
        drive_ld(1'b0, 5'd0, 32'h0);
        #1;
        chk("e_pending", bus.pending_o, 32'h0000_000C);
        chk_wr("e_wr", 1'b1, 5'd1, 32'h0000_0005);
        arst = 1'b1;
        zero_inputs();
        #1;
        chk_wr("e_rst", 1'b0, 5'd0, 32'h0);
        chk("e_rst_pending", bus.pending_o, 32'h0);
        chk("e_rst_alu_ready", 32'(bus.alu_ready_o), 32'd0);
        chk("e_rst_ld_ready", 32'(bus.ld_ready_o), 32'd0);
        tick();
        tick();
        arst = 1'b0;
        #1;
        chk("e_rel_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk_wr("e_quiet", 1'b0, 5'd0, 32'h0);
            chk("e_quiet_pending", bus.pending_o, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Writer side of the core register file: merges ALU and load results onto the register file's single write port (rd_addr/rd_data/rd_en).
- Load results are buffered in a small FIFO. The ALU has priority, bounded by an anti-starvation counter.
- Keeps a pending-write scoreboard so issue can stall on operands whose producer has not yet written back.

Parameters:
- LD_FIFO_DEPTH, 4, load-result FIFO entries; power of two, >=2.
- LD_STARVE_MAX, 3, consecutive cycles a non-empty load FIFO may lose arbitration before loads take forced priority.
- XLEN, REG_ADDR_WIDTH, NUM_REG come from sp_pkg; they are not module parameters.

Ports:
- clk_i  in  1  global clock
- arst_i  in  1  asynchronous active-high reset
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  ALU result accepted this cycle
- alu_rd_i  in  REG_ADDR_WIDTH  ALU destination
- alu_data_i  in  XLEN  ALU result
- ld_valid_i  in  1  load result valid
- ld_ready_o  out  1  load FIFO can accept
- ld_rd_i  in  REG_ADDR_WIDTH  load destination
- ld_data_i  in  XLEN  load data
- rd_addr_o  out  REG_ADDR_WIDTH  register file write address
- rd_data_o  out  XLEN  register file write data
- rd_en_o  out  1  register file write enable
- sb_set_i  in  1  issue marks a destination as pending
- sb_set_addr_i  in  REG_ADDR_WIDTH  destination being issued
- rs1_addr_i  in  REG_ADDR_WIDTH  operand 1 to check
- rs2_addr_i  in  REG_ADDR_WIDTH  operand 2 to check
- rs1_busy_o  out  1  rs1 has a pending write
- rs2_busy_o  out  1  rs2 has a pending write
- pending_o  out  NUM_REG  scoreboard bitmap

Behaviour:
- Reset:
  - While arst_i is high: rd_en_o=0, rd_addr_o=0, rd_data_o=0.
  - pending_o=0, FIFO empty, starvation counter=0.
  - alu_ready_o=0 and ld_ready_o=0.
- Handshakes:
  - Transfers occur on valid&&ready at the rising edge.
  - Inputs must stay stable while valid && !ready.
  - ld_ready_o = !fifo_full, taken from registered state. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Arbitration, evaluated each cycle:
  - force_ld = (starve_cnt == LD_STARVE_MAX).
  - alu_ready_o = !force_ld.
  - If alu_valid_i && alu_ready_o: the ALU wins.
  - Else if the FIFO is non-empty: pop the head.
- Starvation counter:
  - Increments when the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at LD_STARVE_MAX.
- Write port:
  - Registered; 1-cycle latency from the winning transfer to rd_en_o=1, with rd_addr_o/rd_data_o from the winner.
  - rd_en_o=0 in cycles with no winner. rd_addr_o/rd_data_o hold their last values.
  - Results with rd=0 are consumed (handshake completes, FIFO pops) but never raise rd_en_o.
- Load path: a load accepted into an empty FIFO while no ALU is valid writes back 2 cycles after acceptance (push, then pop, then registered port).
- Scoreboard:
  - Set on sb_set_i. The bit clears in the cycle after rd_en_o is asserted for that address.
  - Set and clear of the same address in the same cycle: set wins.
  - sb_set_addr_i=0 is ignored; bit 0 is always 0.
  - rsN_busy_o = pending[rsN_addr_i], combinational, no write-port bypass.
  - Issue must not issue a second write to an address that is already pending. No counting is done. Violations are flagged by an assertion.
- Reset mid-operation: FIFO contents and the scoreboard are discarded; no write is emitted after reset deasserts until a new transfer occurs.

Decomposition:
- sp_pkg gains:
  - typedef wb_req_t, a struct of rd (REG_ADDR_WIDTH) and data (XLEN).
  - LD_FIFO_DEPTH_DEFAULT and LD_STARVE_MAX_DEFAULT localparams.
- Sub-module sp_fifo: synchronous FIFO of wb_req_t with parameter DEPTH; ports push/pop/full/empty; async active-high reset.
- Arbitration, starvation counter and scoreboard live in reg_wb_ctrl.

Test Plan:
- ALU single: alu_valid rd=5 data=0xDEAD_BEEF, sb_set rd=5 earlier -> next cycle rd_en=1 addr=5 data=0xDEADBEEF; pending[5] clears the following cycle, rs1_busy for rs1=5 goes 1->0.
- Load single, ALU idle: ld rd=3 data=0x1234 -> rd_en 2 cycles later, addr=3; ld_ready stays 1.
- FIFO full: push 4 loads while alu_valid held for rd=1 -> ld_ready=0 after the 4th push; the 5th load is held until a forced drain frees an entry.
- Starvation: continuous ALU valid plus 1 queued load -> after 3 losing cycles alu_ready=0 for one cycle, the load writes back, then alu_ready returns to 1.
- x0 and scoreboard corner: ALU rd=0 data=0xFFFF_FFFF -> alu_ready=1, rd_en stays 0; sb_set rd=7 in the same cycle as rd_en for rd=7 -> pending[7] remains 1.
- Reset mid-operation: 2 loads queued, pending=0x0C, assert arst_i -> all outputs 0; after release FIFO is empty and no rd_en occurs without new input.
